// File: rtl/proc_pkg.sv
// Shared processor definitions: PC width, interrupt vectors and sequencer state encoding.
package proc_pkg;

   localparam int ADDR_W = 10;

   localparam logic [ADDR_W-1:0] DIR_TIMER     = 10'h3FA;
   localparam logic [ADDR_W-1:0] DIR_EXCEPTION = 10'h3FB;
   localparam logic [ADDR_W-1:0] DIR_PORT      = 10'h3FC;
   localparam logic [ADDR_W-1:0] DIR_SYSCALL   = 10'h3FD;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      ENTER,
      RETURN
   } isq_state_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO for nested interrupt handlers; top entry is readable combinationally.
module ret_addr_stack #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top_data,
   output logic              full,
   output logic              empty,
   output logic [CW-1:0]     count
);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [IW-1:0]     top_idx;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign top_idx  = IW'(count - CW'(1));
   assign top_data = empty ? '0 : mem[top_idx];

   // Storage needs no reset: only entries below count are ever read.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[IW'(count)] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CW'(1);
      end else if (pop && !empty) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// Core-side interrupt responder: holds one pending request, enters the handler at an
// instruction boundary, and returns to the saved PC on reti.
module interrupt_sequencer
   import proc_pkg::*;
#(
   parameter int ADDR_W = proc_pkg::ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       s_interruption,
   input  logic [ADDR_W-1:0]          dir_int,
   input  logic                       instr_boundary,
   input  logic [ADDR_W-1:0]          pc_next,
   input  logic                       reti,
   output logic                       pc_redirect,
   output logic [ADDR_W-1:0]          pc_target,
   output logic                       s_finished,
   output logic                       in_handler,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       err_underflow,
   output logic                       err_overrun
);

   isq_state_t        state;
   logic              pending;
   logic              pending_next;
   logic [ADDR_W-1:0] vec_q;
   logic              boundary_ok;
   logic              take_entry;
   logic              take_ret;
   logic              take_underflow;
   logic              overrun;
   logic              stack_full;
   logic              stack_empty;
   logic [ADDR_W-1:0] top_addr;

   // Boundaries seen while a redirect is flushing fetch belong to a squashed instruction.
   always_comb begin
      boundary_ok    = instr_boundary && ((state == IDLE) || (state == PEND));
      take_ret       = boundary_ok && reti && !stack_empty;
      take_underflow = boundary_ok && reti && stack_empty;
      take_entry     = boundary_ok && !reti && pending && !stack_full;
      overrun        = s_interruption && pending && !take_entry;
      pending_next   = pending;
      if (s_interruption && !overrun) begin
         pending_next = 1'b1;
      end else if (take_entry) begin
         pending_next = 1'b0;
      end
   end

   ret_addr_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (take_entry),
      .pop       (take_ret),
      .push_data (pc_next),
      .top_data  (top_addr),
      .full      (stack_full),
      .empty     (stack_empty),
      .count     (depth)
   );

   assign in_handler = !stack_empty;

   // Redirect target is sampled from vec_q before a same-cycle request can overwrite it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pending       <= 1'b0;
         vec_q         <= '0;
         pc_redirect   <= 1'b0;
         pc_target     <= '0;
         s_finished    <= 1'b0;
         err_underflow <= 1'b0;
         err_overrun   <= 1'b0;
      end else begin
         pc_redirect   <= take_entry || take_ret;
         s_finished    <= take_ret;
         err_underflow <= take_underflow;
         err_overrun   <= overrun;
         pending       <= pending_next;
         if (s_interruption && !overrun) begin
            vec_q <= dir_int;
         end
         if (take_entry) begin
            pc_target <= vec_q;
            state     <= ENTER;
         end else if (take_ret) begin
            pc_target <= top_addr;
            state     <= RETURN;
         end else begin
            state <= pending_next ? PEND : IDLE;
         end
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: each step queues its expected post-edge outputs.
module tb_interrupt_sequencer;
   import proc_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_interruption = 1'b0;
   logic [9:0] dir_int = '0;
   logic       instr_boundary = 1'b0;
   logic [9:0] pc_next = '0;
   logic       reti = 1'b0;
   logic       pc_redirect;
   logic [9:0] pc_target;
   logic       s_finished;
   logic       in_handler;
   logic [2:0] depth;
   logic       err_underflow;
   logic       err_overrun;

   typedef struct {
      string      tag;
      logic       red;
      logic [9:0] tgt;
      logic       chk_tgt;
      logic       fin;
      logic [2:0] dep;
      logic       uf;
      logic       ov;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   interrupt_sequencer #(
      .ADDR_W (10),
      .DEPTH  (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .s_interruption (s_interruption),
      .dir_int        (dir_int),
      .instr_boundary (instr_boundary),
      .pc_next        (pc_next),
      .reti           (reti),
      .pc_redirect    (pc_redirect),
      .pc_target      (pc_target),
      .s_finished     (s_finished),
      .in_handler     (in_handler),
      .depth          (depth),
      .err_underflow  (err_underflow),
      .err_overrun    (err_overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, queue what the outputs must be after the edge, then compare.
   task automatic apply_stimulus(input string tag, input logic rst, input logic si,
                                 input logic [9:0] dir, input logic b, input logic [9:0] pcn,
                                 input logic rt, input logic red, input logic [9:0] tgt,
                                 input logic fin, input logic [2:0] dep, input logic uf,
                                 input logic ov);
      exp_t e;
      reset          = rst;
      s_interruption = si;
      dir_int        = dir;
      instr_boundary = b;
      pc_next        = pcn;
      reti           = rt;
      e.tag = tag; e.red = red; e.tgt = tgt; e.chk_tgt = red | rst;
      e.fin = fin; e.dep = dep; e.uf = uf; e.ov = ov;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_output({e.tag, ".pc_redirect"}, 16'(pc_redirect), 16'(e.red));
      if (e.chk_tgt) check_output({e.tag, ".pc_target"}, 16'(pc_target), 16'(e.tgt));
      check_output({e.tag, ".s_finished"}, 16'(s_finished), 16'(e.fin));
      check_output({e.tag, ".depth"}, 16'(depth), 16'(e.dep));
      check_output({e.tag, ".in_handler"}, 16'(in_handler), 16'(e.dep != 3'd0));
      check_output({e.tag, ".err_underflow"}, 16'(err_underflow), 16'(e.uf));
      check_output({e.tag, ".err_overrun"}, 16'(err_overrun), 16'(e.ov));
   endtask

   initial begin
      logic [9:0] d;
      logic [9:0] t;
      $display("[TB] start");

      apply_stimulus("rst0", 1, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
      apply_stimulus("rst1", 1, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);

      // Basic entry and return; a boundary during the redirect cycle is ignored.
      apply_stimulus("s1_req",   0, 1, DIR_TIMER, 0, 0,      0, 0, 0,         0, 0, 0, 0);
      apply_stimulus("s1_entry", 0, 0, 0,         1, 10'h012, 0, 1, DIR_TIMER, 0, 1, 0, 0);
      apply_stimulus("s1_flush", 0, 0, 0,         1, 0,      1, 0, 0,         0, 1, 0, 0);
      apply_stimulus("s1_reti",  0, 0, 0,         1, 0,      1, 1, 10'h012,   1, 0, 0, 0);
      apply_stimulus("s1_idle",  0, 0, 0,         0, 0,      0, 0, 0,         0, 0, 0, 0);

      // Nesting two levels deep.
      apply_stimulus("s2_req1", 0, 1, DIR_TIMER,     0, 0,       0, 0, 0,             0, 0, 0, 0);
      apply_stimulus("s2_ent1", 0, 0, 0,             1, 10'h012, 0, 1, DIR_TIMER,     0, 1, 0, 0);
      apply_stimulus("s2_req2", 0, 1, DIR_EXCEPTION, 0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s2_ent2", 0, 0, 0,             1, 10'h3FE, 0, 1, DIR_EXCEPTION, 0, 2, 0, 0);
      apply_stimulus("s2_fl1",  0, 0, 0,             0, 0,       0, 0, 0,             0, 2, 0, 0);
      apply_stimulus("s2_ret1", 0, 0, 0,             1, 0,       1, 1, 10'h3FE,       1, 1, 0, 0);
      apply_stimulus("s2_fl2",  0, 0, 0,             0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s2_ret2", 0, 0, 0,             1, 0,       1, 1, 10'h012,       1, 0, 0, 0);
      apply_stimulus("s2_idle", 0, 0, 0,             0, 0,       0, 0, 0,             0, 0, 0, 0);

      // Fill the stack, then a fifth request waits until a reti frees a slot.
      for (int i = 0; i < 4; i++) begin
         d = 10'(DIR_TIMER + 10'(i));
         apply_stimulus("s3_req", 0, 1, d, 0, 0,        0, 0, 0, 0, 3'(i),     0, 0);
         apply_stimulus("s3_ent", 0, 0, 0, 1, 10'(i+1), 0, 1, d, 0, 3'(i + 1), 0, 0);
         apply_stimulus("s3_fl",  0, 0, 0, 0, 0,        0, 0, 0, 0, 3'(i + 1), 0, 0);
      end
      apply_stimulus("s3_req5",  0, 1, DIR_TIMER, 0, 0,       0, 0, 0,         0, 4, 0, 0);
      apply_stimulus("s3_hold1", 0, 0, 0,         1, 10'h005, 0, 0, 0,         0, 4, 0, 0);
      apply_stimulus("s3_hold2", 0, 0, 0,         1, 10'h006, 0, 0, 0,         0, 4, 0, 0);
      apply_stimulus("s3_ret",   0, 0, 0,         1, 0,       1, 1, 10'h004,   1, 3, 0, 0);
      apply_stimulus("s3_fl5",   0, 0, 0,         0, 0,       0, 0, 0,         0, 3, 0, 0);
      apply_stimulus("s3_ent5",  0, 0, 0,         1, 10'h007, 0, 1, DIR_TIMER, 0, 4, 0, 0);
      apply_stimulus("s3_fl6",   0, 0, 0,         0, 0,       0, 0, 0,         0, 4, 0, 0);
      for (int k = 0; k < 4; k++) begin
         t = (k == 0) ? 10'h007 : 10'(4 - k);
         apply_stimulus("s3_unw", 0, 0, 0, 1, 0, 1, 1, t, 1, 3'(3 - k), 0, 0);
         apply_stimulus("s3_ufl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'(3 - k), 0, 0);
      end

      // reti wins over a pending entry; a second request while pending is an overrun.
      apply_stimulus("s4_req1", 0, 1, DIR_TIMER,     0, 0,       0, 0, 0,             0, 0, 0, 0);
      apply_stimulus("s4_ent1", 0, 0, 0,             1, 10'h010, 0, 1, DIR_TIMER,     0, 1, 0, 0);
      apply_stimulus("s4_fl1",  0, 0, 0,             0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s4_req2", 0, 1, DIR_EXCEPTION, 0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s4_coll", 0, 0, 0,             1, 10'h0AA, 1, 1, 10'h010,       1, 0, 0, 0);
      apply_stimulus("s4_fl2",  0, 0, 0,             0, 0,       0, 0, 0,             0, 0, 0, 0);
      apply_stimulus("s4_ent2", 0, 0, 0,             1, 10'h020, 0, 1, DIR_EXCEPTION, 0, 1, 0, 0);
      apply_stimulus("s4_fl3",  0, 0, 0,             0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s4_req3", 0, 1, DIR_PORT,      0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s4_ovr",  0, 1, DIR_SYSCALL,   0, 0,       0, 0, 0,             0, 1, 0, 1);
      apply_stimulus("s4_ovr0", 0, 0, 0,             0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s4_ent3", 0, 0, 0,             1, 10'h030, 0, 1, DIR_PORT,      0, 2, 0, 0);
      apply_stimulus("s4_fl4",  0, 0, 0,             0, 0,       0, 0, 0,             0, 2, 0, 0);
      apply_stimulus("s4_ret1", 0, 0, 0,             1, 0,       1, 1, 10'h030,       1, 1, 0, 0);
      apply_stimulus("s4_fl5",  0, 0, 0,             0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s4_ret2", 0, 0, 0,             1, 0,       1, 1, 10'h020,       1, 0, 0, 0);
      apply_stimulus("s4_fl6",  0, 0, 0,             0, 0,       0, 0, 0,             0, 0, 0, 0);

      // reti with nothing to return to.
      apply_stimulus("s5_uf",  0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
      apply_stimulus("s5_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset while two deep with a request pending discards everything.
      apply_stimulus("s6_req1", 0, 1, DIR_TIMER,     0, 0,       0, 0, 0,             0, 0, 0, 0);
      apply_stimulus("s6_ent1", 0, 0, 0,             1, 10'h040, 0, 1, DIR_TIMER,     0, 1, 0, 0);
      apply_stimulus("s6_fl1",  0, 0, 0,             0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s6_req2", 0, 1, DIR_EXCEPTION, 0, 0,       0, 0, 0,             0, 1, 0, 0);
      apply_stimulus("s6_ent2", 0, 0, 0,             1, 10'h050, 0, 1, DIR_EXCEPTION, 0, 2, 0, 0);
      apply_stimulus("s6_fl2",  0, 0, 0,             0, 0,       0, 0, 0,             0, 2, 0, 0);
      apply_stimulus("s6_req3", 0, 1, DIR_PORT,      0, 0,       0, 0, 0,             0, 2, 0, 0);
      apply_stimulus("s6_rst",  1, 0, 0,             0, 0,       0, 0, 10'h000,       0, 0, 0, 0);
      apply_stimulus("s6_post", 0, 0, 0,             0, 0,       0, 0, 0,             0, 0, 0, 0);
      apply_stimulus("s6_nopd", 0, 0, 0,             1, 10'h060, 0, 0, 0,             0, 0, 0, 0);
      apply_stimulus("s6_uf",   0, 0, 0,             1, 0,       1, 0, 0,             0, 0, 1, 0);
      apply_stimulus("s6_idle", 0, 0, 0,             0, 0,       0, 0, 0,             0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
